// File: rtl/posit_arb_pkg.sv
// ------------------------------------------------------------------
// posit_arb_pkg: shared types and round-robin pick for the posit adder arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package posit_arb_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 4;
  localparam int MAX_REQ  = 8;
  localparam int ID_MAX_W = 3;

  typedef logic [POSIT_N-1:0] posit_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    posit_t              data;
  } rsp_entry_t;

  typedef struct packed {
    logic                found;
    logic [ID_MAX_W-1:0] idx;
  } rr_pick_t;

  // Scan from the farthest offset down so the nearest valid index at/after ptr wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [ID_MAX_W-1:0] ptr,
                                       input int nreq);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = ID_MAX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/posit_add_arbiter_if.sv
// ------------------------------------------------------------------
// posit_add_arbiter_if: request, adder and response channels of the arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface posit_add_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [N-1:0]      add_a;
  logic [N-1:0]      add_b;
  logic [N-1:0]      add_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [N-1:0]      rsp_data;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, add_res, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, add_res, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/posit_rsp_fifo.sv
// ------------------------------------------------------------------
// posit_rsp_fifo: synchronous FIFO of tagged adder results
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module posit_rsp_fifo
  import posit_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  rsp_entry_t                          push_data,
  input  logic                                pop,
  output rsp_entry_t                          head,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rsp_entry_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/posit_add_arbiter.sv
// ------------------------------------------------------------------
// posit_add_arbiter: round-robin sharing of one pipelined posit adder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module posit_add_arbiter
  import posit_arb_pkg::*;
#(
  parameter int N          = POSIT_N,
  parameter int ES         = POSIT_ES,
  parameter int NREQ       = 4,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  posit_add_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(NREQ);
  // Stage 0 tracks the operand register, stages 1..ADD_LAT track the adder.
  localparam int PIPE  = ADD_LAT + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]  rr_ptr;
  rr_pick_t         pick;
  logic [ID_W-1:0]  grant;
  logic             issue;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             credit_ok;
  logic [PIPE-1:0]  tag_v;
  logic [ID_W-1:0]  tag_id [PIPE];
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  rsp_entry_t       push_entry;
  rsp_entry_t       head;

  always_comb begin
    pick          = rr_pick(MAX_REQ'(bus.req_valid), ID_MAX_W'(rr_ptr), NREQ);
    grant         = pick.idx[ID_W-1:0];
    credit_used   = {1'b0, inflight} + {1'b0, fifo_count};
    credit_ok     = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
    issue         = pick.found && credit_ok && !reset;
    bus.req_ready = '0;
    if (issue) bus.req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      bus.add_a <= '0;
      bus.add_b <= '0;
      tag_v     <= '0;
      inflight  <= '0;
      for (int k = 0; k < PIPE; k++) tag_id[k] <= '0;
    end else begin
      if (issue) begin
        bus.add_a <= bus.req_a[grant*N +: N];
        bus.add_b <= bus.req_b[grant*N +: N];
        rr_ptr    <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
      tag_v     <= {tag_v[PIPE-2:0], issue};
      tag_id[0] <= grant;
      for (int k = 1; k < PIPE; k++) tag_id[k] <= tag_id[k-1];
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign push            = tag_v[PIPE-1];
  assign push_entry.id   = ID_MAX_W'(tag_id[PIPE-1]);
  assign push_entry.data = posit_t'(bus.add_res);
  assign pop             = bus.rsp_valid && bus.rsp_ready;

  posit_rsp_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_id    = fifo_empty ? '0 : head.id[ID_W-1:0];
  assign bus.rsp_data  = fifo_empty ? '0 : N'(head.data);
  assign bus.busy      = (inflight != '0) || (fifo_count != '0);

  a_params:      assert property (@(posedge clk) (ES >= 0) && (FIFO_DEPTH >= PIPE));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));
  a_pick_range:  assert property (@(posedge clk) disable iff (reset) !pick.found || (pick.idx < NREQ));
  a_head_range:  assert property (@(posedge clk) disable iff (reset) fifo_empty || (head.id < NREQ));

endmodule

`default_nettype wire

// File: tb/tb_posit_add_arbiter.sv
// ------------------------------------------------------------------
// tb_posit_add_arbiter: directed bench with response scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_posit_add_arbiter;

  localparam int N          = 32;
  localparam int NREQ       = 4;
  localparam int ADD_LAT    = 1;
  localparam int FIFO_DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   issued;

  logic [39:0] exp_q [$];
  logic [39:0] exp_e;
  logic [N-1:0] res_pipe [ADD_LAT];
  logic [3:0]  rr_seq [4];

  posit_add_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  posit_add_arbiter #(
    .N          (N),
    .ES         (4),
    .NREQ       (NREQ),
    .ADD_LAT    (ADD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Stand-in adder: any fixed function of the operands, delayed ADD_LAT cycles.
  function automatic logic [N-1:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b);
    return a + b;
  endfunction

  always @(posedge clk) begin
    res_pipe[0] <= model_add(bus.add_a, bus.add_b);
    for (int k = 1; k < ADD_LAT; k++) res_pipe[k] <= res_pipe[k-1];
  end
  assign bus.add_res = res_pipe[ADD_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes enqueue expected {id,sum}, pops must match in order.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("sb_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("sb_id", bus.rsp_id, exp_e[39:32]);
          check("sb_data", bus.rsp_data, exp_e[31:0]);
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          exp_q.push_back({8'(i), model_add(bus.req_a[i*N +: N], bus.req_b[i*N +: N])});
      check("ready_onehot0", $onehot0(bus.req_ready), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.req_a[i*N +: N] = a;
    bus.req_b[i*N +: N] = b;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40 && bus.busy; i++) step();
    check("drain_idle", bus.busy, 0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_add_a", bus.add_a, 0);
    check("rst_add_b", bus.add_b, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_busy", bus.busy, 0);

    // Single op from requester 0
    reset = 1'b0;
    set_ops(0, 32'h5F00_0000, 32'hA500_0000);
    bus.req_valid = 4'b0001;
    #1;
    check("t1_ready", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    check("t1_add_a", bus.add_a, 32'h5F00_0000);
    check("t1_add_b", bus.add_b, 32'hA500_0000);
    check("t1_busy", bus.busy, 1);
    check("t1_not_yet", bus.rsp_valid, 0);
    step();
    check("t1_lat_early", bus.rsp_valid, 0);
    step();
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_rsp_id", bus.rsp_id, 0);
    check("t1_rsp_data", bus.rsp_data, 32'h0400_0000);
    step();
    check("t1_hold", bus.rsp_data, 32'h0400_0000);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("t1_popped", bus.rsp_valid, 0);
    check("t1_idle", bus.busy, 0);

    // All requesters valid, full throughput
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1) << 24, 32'h11 * (i + 1));
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    for (int c = 0; c < 12; c++) begin
      check("t2_grant", bus.req_ready, 64'(1) << (c % 4));
      step();
      if (c >= 2) check("t2_rsp_stream", bus.rsp_valid, 1);
    end
    drain();

    // Backpressure: credit limits issues to FIFO_DEPTH
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.req_ready != '0) issued++;
      step();
    end
    check("t3_issues", issued, FIFO_DEPTH);
    check("t3_blocked", bus.req_ready, 0);
    check("t3_head_id", bus.rsp_id, 0);
    check("t3_head_data", bus.rsp_data, model_add(32'h0100_0000, 32'h11));
    step();
    step();
    check("t3_stable", bus.rsp_data, model_add(32'h0100_0000, 32'h11));
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    #1;
    issued = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.req_ready != '0) issued++;
      step();
    end
    check("t3_one_more", issued, 1);
    check("t3_head_id2", bus.rsp_id, 1);
    drain();

    // Sparse requesters 1 and 3 starting from rr_ptr=2
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    check("t4_first", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b1010;
    #1;
    rr_seq = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    for (int c = 0; c < 4; c++) begin
      check("t4_grant", bus.req_ready, rr_seq[c]);
      step();
    end
    drain();

    // Reset with two ops in flight and one in the FIFO
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    step();
    step();
    step();
    check("t5_fifo_one", bus.rsp_valid, 1);
    check("t5_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("t5_ready_in_reset", bus.req_ready, 0);
    step();
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    check("t5_rsp_cleared", bus.rsp_valid, 0);
    check("t5_busy_cleared", bus.busy, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t5_no_stale", bus.rsp_valid, 0);
    end
    bus.req_valid = 4'hF;
    #1;
    check("t5_rr_restart", bus.req_ready, 4'b0001);
    step();
    drain();

    // Random traffic across pointer wrap with mixed backpressure
    do_reset();
    issued = 0;
    for (int c = 0; c < 3000 && issued < 64; c++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.req_ready != '0) issued++;
      step();
    end
    check("t6_issued", issued, 64);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
